// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing derivation.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_e;
`else
    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_e;
`endif

    function automatic int unsigned cycles_per_bit(input int unsigned clk_freq,
                                                   input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int unsigned half_bit(input int unsigned cpb);
        return cpb / 32'd2;
    endfunction

    // Even-parity bit of a zero-extended vector (XOR of all bits).
    function automatic logic parity_of(input logic [63:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous serial input; both cells reset to
// RESET_VAL so an idle-high line does not look like a falling edge out of reset.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage metastability filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_byte_receiver.sv
// UART byte receiver: mid-bit sampling of start/data/stop, registered strobes.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD_RATE    = 115_200,
    parameter int unsigned PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uart_rxd,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_busy
);

    localparam int unsigned CPB   = cycles_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF  = half_bit(CPB);
    localparam int          CNT_W = $clog2(CPB + 1);
    localparam int          IDX_W = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

    localparam logic [CNT_W-1:0] CPB_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PAYLOAD_BITS - 1);

    logic                    rxd_s;
    logic                    bit_tick_s;
    logic                    half_tick_s;
    logic                    stop_ok_s;

    rx_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    busy_q, busy_d;
    logic                    prev_q, prev_d;
`ifdef UART_RX_PARITY_EN
    logic                    par_err_q, par_err_d;
`endif

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (uart_rxd),
        .q_o   (rxd_s)
    );

    assign bit_tick_s  = (cnt_q == CPB_LAST);
    assign half_tick_s = (cnt_q == HALF_LAST);
`ifdef UART_RX_PARITY_EN
    assign stop_ok_s   = rxd_s & ~par_err_q;
`else
    assign stop_ok_s   = rxd_s;
`endif

    // Next-state, datapath and strobe computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        prev_d  = rxd_s;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rxd_s) begin
                    state_d = RX_START;
`ifdef UART_RX_PARITY_EN
                    par_err_d = 1'b0;
`endif
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (half_tick_s) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A line that is high again at mid-start was only a glitch.
                    if (!rxd_s) begin
                        state_d = RX_DATA;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (bit_tick_s) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[PAYLOAD_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = RX_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (bit_tick_s) begin
                    cnt_d     = '0;
                    par_err_d = parity_of(64'(shift_q)) ^ rxd_s;
                    state_d   = RX_STOP;
                end else begin
                    state_d = RX_PARITY;
                end
            end
`endif
            RX_STOP: begin
                if (bit_tick_s) begin
                    cnt_d = '0;
                    if (stop_ok_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d = 1'b1;
                        // A low stop bit may be a break; wait for the line to rise.
                        if (rxd_s) begin
                            state_d = RX_IDLE;
                        end else begin
                            state_d = RX_WAIT_IDLE;
                        end
                    end
                end else begin
                    state_d = RX_STOP;
                end
            end
            RX_WAIT_IDLE: begin
                cnt_d = '0;
                if (rxd_s) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_WAIT_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
        busy_d = (state_d != RX_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
            prev_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
            prev_q  <= prev_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign uart_rx_data      = data_q;
    assign uart_rx_valid     = valid_q;
    assign uart_rx_frame_err = ferr_q;
    assign uart_rx_busy      = busy_q;

endmodule

// File: doc/uart_byte_receiver.md
UART_BYTE_RECEIVER -- requirements
Module: uart_byte_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning the line bit rate.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 8, meaning data bits per frame, sent LSB first.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port uart_rxd, input, 1 bit: the asynchronous serial line; it idles high.
REQ-007 SHALL have port uart_rx_data, output, PAYLOAD_BITS wide: the last good byte received.
REQ-008 SHALL have port uart_rx_valid, output, 1 bit: a one-cycle strobe when uart_rx_data updates.
REQ-009 SHALL have port uart_rx_frame_err, output, 1 bit: a one-cycle strobe when a frame is bad.
REQ-010 SHALL have port uart_rx_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL pass uart_rxd through a 2-flop synchronizer; all decisions use the synchronized value. The synchronizer cells reset to 1.
REQ-012 SHALL use CYCLES_PER_BIT = CLK_FREQ/BAUD_RATE (integer division; 434 at the defaults) and HALF_BIT = CYCLES_PER_BIT/2 (217).
REQ-013 SHALL implement states IDLE, START, DATA, STOP and WAIT_IDLE, plus PARITY when the macro in REQ-024 is defined.
REQ-014 IDLE: on a synchronized falling edge (previous 1, current 0), SHALL clear the baud counter and go to START.
REQ-015 START: at HALF_BIT cycles, if the line is 0, SHALL go to DATA with the counter cleared; if the line is 1, SHALL treat it as a glitch and return to IDLE with no strobe.
REQ-016 DATA: SHALL sample every CYCLES_PER_BIT cycles (mid-bit) and shift right into a shift register, MSB in, so that after PAYLOAD_BITS samples bit0 is the first bit received.
REQ-017 DATA: a 3-bit bit index SHALL wrap only on leaving DATA; after the last sample the state goes to STOP (or PARITY).
REQ-018 STOP: at the mid-bit sample, a line value of 1 SHALL load uart_rx_data from the shift register, pulse uart_rx_valid for exactly one cycle on the next clk, and go to IDLE.
REQ-019 STOP: a line value of 0 SHALL leave uart_rx_data unchanged, pulse uart_rx_frame_err for one cycle, and go to WAIT_IDLE.
REQ-020 WAIT_IDLE: SHALL stay until the synchronized line reads 1, then go to IDLE; a held-low break therefore yields exactly one frame_err.
REQ-021 uart_rx_data SHALL hold its value between strobes. uart_rx_valid and uart_rx_frame_err SHALL never be high in the same cycle.
REQ-022 Latency: the valid strobe SHALL occur 1 cycle after the mid-stop sample, about 9.5 bit times after the start edge plus 3 cycles.

Reset
REQ-023 While rst is 0, SHALL force: state IDLE, counters 0, shift register 0, uart_rx_data 0, uart_rx_valid 0, uart_rx_frame_err 0, uart_rx_busy 0. A frame in progress is discarded, and reception restarts only on a fresh falling edge after rst deasserts.

Configuration
REQ-024 With macro UART_RX_PARITY_EN defined, SHALL expect one even-parity bit after the data bits, sampled mid-bit in state PARITY.
REQ-025 With UART_RX_PARITY_EN defined, a parity mismatch SHALL be latched; at STOP, a latched mismatch SHALL give frame_err instead of valid, regardless of the stop bit value.
REQ-026 Without UART_RX_PARITY_EN, SHALL have no PARITY state and no parity logic; a frame is 8N1.

Structure
REQ-027 Package uart_pkg SHALL hold the rx state enum typedef and the CYCLES_PER_BIT/HALF_BIT derivation functions; these are shared with the uart transmitter.
REQ-028 The synchronizer SHALL be sub-module uart_rx_sync (2 flops, parameterized reset value); all other logic SHALL be in uart_byte_receiver.

Verification
REQ-029 Send 0x5A in 8N1 at 115200 on a 50 MHz clk -> exactly one uart_rx_valid pulse, uart_rx_data = 0x5A, busy high for about 9.5 bit times.
REQ-030 Drive a 100-cycle low glitch on the idle line -> no valid and no frame_err strobe, and the receiver is back in IDLE; a following 0xC3 is received correctly.
REQ-031 Send 0x00 then 0xFF back-to-back with a single stop bit -> two valid pulses, data 0x00 then 0xFF.
REQ-032 Send 0x81 with the stop bit forced to 0, then hold the line low for 20 bit times -> one frame_err pulse, no valid, uart_rx_data keeps its previous value; recovery after the line returns high.
REQ-033 Assert rst at the 4th data bit of 0x3C, release it, then send 0xA5 -> no strobe for the aborted frame; valid with data 0xA5.
REQ-034 With UART_RX_PARITY_EN: send 0x07 with the correct parity bit 1 -> valid; send 0x07 with parity bit 0 -> frame_err, no valid.
